// File: rtl/rle_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : rle_decoder
//  Purpose  : Run-length decoder. Expands (value, run) tokens into run+1
//             identical coefficient samples on a valid/ready stream, and tags
//             each sample with its position inside a BLOCK_LEN-sample block.
//  Revision : 1.0 - initial release
// ============================================================================
module rle_decoder #(
    parameter int DATA_W    = 17,
    parameter int RUN_W     = 4,
    parameter int BLOCK_LEN = 8,
    parameter int POS_W     = $clog2(BLOCK_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_value,
    input  logic [RUN_W-1:0]  in_run,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [POS_W-1:0]  out_pos
);

    localparam logic [POS_W-1:0] C_POS_MAX = POS_W'(BLOCK_LEN - 1);
    localparam logic [POS_W-1:0] C_POS_ONE = POS_W'(1);
    localparam logic [RUN_W-1:0] C_RUN_ONE = RUN_W'(1);

    // IDLE: nothing presented downstream. EMIT: out_valid is high.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state;
    logic [RUN_W-1:0]    r_rem;
    logic [RUN_W-1:0]    w_rem;
    logic [POS_W-1:0]    r_pos;
    logic [POS_W-1:0]    w_pos;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data;
    logic                w_in_fire;
    logic                w_out_fire;

    assign out_valid  = (r_state == ST_EMIT);
    assign out_data   = r_data;
    assign out_pos    = r_pos;
    assign out_last   = out_valid && (r_pos == C_POS_MAX);

    // A new token is taken when idle, or when the last repeat of the current
    // token leaves this cycle, so consecutive tokens stream with no bubble.
    assign in_ready   = !clear && (!out_valid || (out_ready && (r_rem == '0)));
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // State, repeat counter, block position and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_pos   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state;
            r_rem   <= w_rem;
            r_pos   <= w_pos;
            r_data  <= w_data;
        end
    end

    // Next-state logic: clear wins over everything but leaves data untouched.
    always_comb begin
        w_state = r_state;
        w_rem   = r_rem;
        w_pos   = r_pos;
        w_data  = r_data;
        if (clear) begin
            w_state = ST_IDLE;
            w_rem   = '0;
            w_pos   = '0;
        end else begin
            if (w_out_fire) begin
                w_pos = (r_pos == C_POS_MAX) ? '0 : (r_pos + C_POS_ONE);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_in_fire) begin
                        w_state = ST_EMIT;
                        w_data  = in_value;
                        w_rem   = in_run;
                    end
                end
                ST_EMIT: begin
                    if (w_out_fire) begin
                        if (r_rem != '0) begin
                            w_rem = r_rem - C_RUN_ONE;
                        end else if (w_in_fire) begin
                            w_data = in_value;
                            w_rem  = in_run;
                        end else begin
                            w_state = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rle_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rle_decoder
//  Purpose  : Directed self-checking bench for rle_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rle_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_value;
    logic [3:0]  in_run;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_data;
    logic        out_last;
    logic [2:0]  out_pos;

    int compared   = 0;
    int mismatched = 0;

    rle_decoder #(.DATA_W(17), .RUN_W(4), .BLOCK_LEN(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_run    (in_run),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_pos   (out_pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_sample(input string tag, input logic [16:0] d,
                                input logic [2:0] p, input logic l);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".pos"},   32'(out_pos),   32'(p));
        check({tag, ".last"},  32'(out_last),  32'(l));
    endtask

    // One cycle of clear with no token offered; leaves block position at 0.
    task automatic do_clear();
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        clear    = 1'b0;
        check("clear.valid", 32'(out_valid), 32'd0);
        check("clear.pos",   32'(out_pos),   32'd0);
    endtask

    logic [16:0] b2b_data [9];
    logic [16:0] tok_val  [3];
    logic [3:0]  tok_run  [3];

    initial begin
        int fired;
        int t;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_value = '0; in_run = '0; out_ready = 1'b0;

        // ---- reset ----
        @(negedge clk);
        @(negedge clk);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data",  32'(out_data),  32'd0);
        check("rst.last",  32'(out_last),  32'd0);
        check("rst.pos",   32'(out_pos),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready", 32'(in_ready), 32'd1);

        // ---- single token, run 0 ----
        in_valid = 1'b1; in_value = 17'h00123; in_run = 4'd0; out_ready = 1'b1;
        #1 check("single.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_sample("single.s0", 17'h00123, 3'd0, 1'b0);
        @(negedge clk);
        check("single.idle", 32'(out_valid), 32'd0);
        check("single.hold", 32'(out_data),  32'h00123);

        // ---- backpressure, value -5 run 3, out_ready 1,0,1,0,... ----
        do_clear();
        in_valid = 1'b1; in_value = 17'h1FFFB; in_run = 4'd3; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        fired = 0;
        for (int i = 0; i < 7; i++) begin
            check_sample("bp", 17'h1FFFB, 3'(fired), 1'b0);
            out_ready = (i % 2 == 0);
            #1 check("bp.in_ready", 32'(in_ready), 32'((fired == 3) && out_ready));
            if (out_ready) fired++;
            @(negedge clk);
        end
        check("bp.idle", 32'(out_valid), 32'd0);
        check("bp.pos",  32'(out_pos),   32'd4);

        // ---- back-to-back full rate: A run2, B run4, C run0 ----
        do_clear();
        tok_val[0] = 17'h0AAAA; tok_run[0] = 4'd2;
        tok_val[1] = 17'h1BBBB; tok_run[1] = 4'd4;
        tok_val[2] = 17'h00C0C; tok_run[2] = 4'd0;
        for (int i = 0; i < 9; i++)
            b2b_data[i] = (i < 3) ? tok_val[0] : ((i < 8) ? tok_val[1] : tok_val[2]);
        out_ready = 1'b1;
        t = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0)
                check_sample("b2b", b2b_data[c-1], 3'((c - 1) % 8), (c - 1) == 7);
            in_valid = (t < 3);
            in_value = (t < 3) ? tok_val[t] : 17'h0;
            in_run   = (t < 3) ? tok_run[t] : 4'd0;
            #1 if (in_valid && in_ready) t++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b.tokens", 32'(t), 32'd3);
        check("b2b.idle",   32'(out_valid), 32'd0);

        // ---- maximum run: 16 samples, two block ends ----
        do_clear();
        in_valid = 1'b1; in_value = 17'd7; in_run = 4'd15;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_sample("maxrun", 17'd7, 3'(i % 8), (i % 8) == 7);
            @(negedge clk);
        end
        check("maxrun.idle", 32'(out_valid), 32'd0);

        // ---- clear after 2 of 5 samples, with a competing token ----
        do_clear();
        in_valid = 1'b1; in_value = 17'h15555; in_run = 4'd4;
        @(negedge clk);
        in_valid = 1'b0;
        check_sample("clr.s0", 17'h15555, 3'd0, 1'b0);
        @(negedge clk);
        check_sample("clr.s1", 17'h15555, 3'd1, 1'b0);
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_value = 17'h00000; in_run = 4'd1;
        #1 check("clr.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        check("clr.valid", 32'(out_valid), 32'd0);
        check("clr.pos",   32'(out_pos),   32'd0);
        check("clr.last",  32'(out_last),  32'd0);
        check("clr.hold",  32'(out_data),  32'h15555);
        #1 check("clr.in_ready2", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_sample("clr.z0", 17'h00000, 3'd0, 1'b0);
        @(negedge clk);
        check_sample("clr.z1", 17'h00000, 3'd1, 1'b0);
        @(negedge clk);
        check("clr.idle", 32'(out_valid), 32'd0);

        // ---- asynchronous reset mid-run ----
        do_clear();
        in_valid = 1'b1; in_value = 17'h0ABCD; in_run = 4'd5;
        @(negedge clk);
        in_valid = 1'b0;
        check_sample("arst.s0", 17'h0ABCD, 3'd0, 1'b0);
        @(negedge clk);
        check_sample("arst.s1", 17'h0ABCD, 3'd1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(out_valid), 32'd0);
        check("arst.data",  32'(out_data),  32'd0);
        check("arst.pos",   32'(out_pos),   32'd0);
        check("arst.last",  32'(out_last),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst.in_ready", 32'(in_ready), 32'd1);
        check("arst.idle",     32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rle_decoder.md
Name: rle_decoder

Overview:
- Run-length decoder. It is the inverse of the RLE encoder stage in the DCT+RLE compression path.
- It accepts (value, run) tokens and expands each token into run+1 identical DCT-coefficient samples.
- Every sample is tagged with its position in an 8-coefficient block.
- It sits on the decompression side and feeds the inverse-DCT row engine through a valid/ready stream.

Parameters:
- DATA_W, 17: coefficient width; matches the DCT coefficient/ROM output width.
- RUN_W, 4: run-field width; one token expands to 1..2^RUN_W samples.
- BLOCK_LEN, 8: samples per DCT block; sets out_last spacing.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; drops the pending token and zeroes the block position.
- in_valid  in  1  token present.
- in_ready  out  1  decoder can take a token this cycle.
- in_value  in  DATA_W  coefficient value, two's complement.
- in_run  in  RUN_W  extra repeats; token emits in_run+1 samples.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  decoded coefficient.
- out_last  out  1  current sample is the last of a block.
- out_pos  out  clog2(BLOCK_LEN)  index of the current sample in its block.

Behaviour:
- Reset: rst_n is asynchronous active-low; assertion clears everything immediately, including mid-run.
  - out_valid=0, out_data=0, out_last=0, out_pos=0.
  - Internal remaining-count rem_q=0.
  - in_ready=1 once rst_n is high.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Acceptance rule: in_ready = !clear & (!out_valid | (out_ready & rem_q==0)).
  - This is a combinational path from out_ready to in_ready and is permitted.
  - Tokens are never accepted while clear=1.
- States: IDLE (out_valid=0) and EMIT (out_valid=1).
  - IDLE + in_fire -> EMIT. Load out_data<=in_value, rem_q<=in_run.
  - EMIT + out_fire + rem_q>0 -> EMIT. rem_q decrements; out_data holds.
  - EMIT + out_fire + rem_q==0 + in_fire -> EMIT. Load the new token in the same edge; there is no bubble.
  - EMIT + out_fire + rem_q==0 + !in_fire -> IDLE. out_valid<=0; out_data holds its last value.
  - EMIT + !out_ready -> no change. out_data, out_pos and out_last are stable while out_valid=1.
- Latency and throughput:
  - A token accepted at edge N shows its first sample at out_valid after edge N (1 cycle).
  - Sustained rate is 1 sample/cycle with out_ready=1 and back-to-back tokens.
- Block position:
  - pos_q increments on each out_fire and wraps from BLOCK_LEN-1 to 0.
  - out_pos = pos_q.
  - out_last = out_valid & (pos_q==BLOCK_LEN-1).
  - Tokens may straddle a block boundary; samples continue into the next block with pos wrapping.
- Run arithmetic:
  - in_run is unsigned; the maximum run 2^RUN_W-1 yields 2^RUN_W samples.
  - in_value passes through unmodified. There is no sign extension or rounding.
- clear:
  - On the edge where clear=1: out_valid<=0, rem_q<=0, pos_q<=0.
  - out_data holds its value.
  - clear overrides a simultaneous in_valid or out_fire. A sample presented in that cycle counts as delivered only if out_ready=1, but pos_q still resets to 0.
- Zero value: in_value=0 is an ordinary coefficient and is emitted like any other.

Test Plan:
- Reset check: hold rst_n=0 -> out_valid=0, out_data=0, out_last=0, out_pos=0. Release -> in_ready=1 on the next cycle.
- Single token value=17'h00123, run=0, out_ready=1 -> exactly one out_data=0x00123 one cycle after accept, out_pos=0. Then IDLE.
- Backpressure: token value=-5 (17'h1FFFB), run=3; out_ready toggles 1,0,1,0... -> four samples of 0x1FFFB. Data is stable during stalls. in_ready=0 until the 4th sample fires.
- Back-to-back full rate: tokens (A,run 2), (B,run 4), (C,run 0), out_ready=1 -> AAABBBBBC on 9 consecutive cycles with no gap. out_last on the 8th sample (B); C has out_pos=0.
- Boundary/max run: token value=7, run=15 -> 16 samples of 7. out_last asserts twice (samples 8 and 16); out_pos wraps 7->0.
- Mid-run interrupts:
  - clear after 2 of 5 samples -> out_valid=0 next cycle, out_pos=0; the following token starts cleanly.
  - rst_n pulse asynchronously mid-run -> outputs zero immediately without a clock edge.
